mem_responder: RTL and testbench
================================

Name: mem_responder

Overview:
- Memory-side responder for the multicycle RISC-V CPU; answers the load/store/fetch requests the control unit issues in its MemRead, MemWrite and Fetch states.
- Single unified word-organised RAM with a req/ready handshake, a configurable number of wait states, RV32I byte/halfword/word sizing with load sign/zero extension, and an error response for illegal accesses.
- Sits between the datapath address/write-data mux and the instruction/data registers.

Parameters:
- ADDR_WIDTH, 10, log2 of memory depth in 32-bit words (byte address space = 2^(ADDR_WIDTH+2)).
- WAIT_CYCLES, 1, extra cycles between accept and response; 0 is legal.

Ports:
- clk  input  1  single clock, all logic on posedge.
- reset  input  1  synchronous, active-low reset (reset==0 resets on a clk edge).
- req  input  1  request valid.
- we  input  1  1 = store, 0 = load/fetch.
- addr  input  32  byte address.
- funct3  input  3  RV32I size code (loads 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu; stores 000 sb, 001 sh, 010 sw).
- wdata  input  32  store data, right-aligned.
- ready  output  1  high only in IDLE; accept = req && ready.
- resp_valid  output  1  one-cycle response strobe.
- rdata  output  32  extended load data, valid with resp_valid.
- err  output  1  access error, valid with resp_valid.

Behaviour:
- Interface: one clock; reset is synchronous and active-low.
- Reset (reset==0 at a clk edge):
  - state=IDLE, ready=1 after reset deasserts, resp_valid=0, rdata=0, err=0, wait counter=0.
  - RAM contents are not cleared.
- FSM states IDLE, WAIT, RESP.
  - IDLE: on accept, latch we/addr/funct3/wdata. Go to WAIT if WAIT_CYCLES>0, else RESP.
  - WAIT: count WAIT_CYCLES cycles, then go to RESP.
  - RESP: resp_valid=1, rdata/err held for exactly one cycle, then IDLE unconditionally.
- Access timing:
  - The RAM access happens on the clk edge entering RESP: the write commits and rdata registers on that edge.
  - resp_valid is first high WAIT_CYCLES+1 cycles after the accept cycle.
  - Maximum throughput is 1 transaction per WAIT_CYCLES+2 cycles.
- Input sampling:
  - req is ignored while not IDLE.
  - Inputs may change after accept without effect.
  - req held high through RESP is accepted again in the following IDLE cycle.
- Load lane selection:
  - lb/lbu select byte addr[1:0]; lh/lhu select halfword addr[1]; lw takes the whole word.
  - lb/lh sign-extend; lbu/lhu zero-extend.
- Store lane placement:
  - sb writes wdata[7:0] to byte lane addr[1:0]; sh writes wdata[15:0] to halfword lane addr[1]; sw writes all 4 lanes.
  - Unselected lanes are preserved.
  - rdata=0 on a store response.
- Error conditions:
  - addr[31:ADDR_WIDTH+2] nonzero (out of range).
  - Illegal funct3: loads 011/110/111; stores anything other than 000/001/010.
  - On error: err=1, rdata=0, no RAM write.
- Misalignment: see Optional Feature.
- Reset asserted mid-transaction (WAIT or RESP): returns to IDLE with reset values. A store not yet committed is dropped; no resp_valid is generated for it.

Optional Feature:
- Macro: MEM_MISALIGN_CHECK_EN.
- Defined:
  - lh/lhu/sh with addr[0]=1, and lw/sw with addr[1:0]!=0, respond err=1, rdata=0, no write.
- Undefined:
  - Low address bits are forced to natural alignment (addr[0] cleared for halfword, addr[1:0] cleared for word).
  - The access proceeds normally with err=0.

Test Plan:
- Reset then idle (WAIT_CYCLES=1): ready=1, resp_valid=0, rdata=0, err=0.
- sw addr=0x10 wdata=0xDEADBEEF, then lw 0x10:
  - store resp_valid 2 cycles after accept with err=0, rdata=0.
  - load returns 0xDEADBEEF.
- Extension and byte store against that word:
  - lb 0x13 -> 0xFFFFFFDE; lbu 0x13 -> 0x000000DE; lh 0x12 -> 0xFFFFDEAD; lhu 0x10 -> 0x0000BEEF.
  - sb 0x11 wdata=0x55, then lw 0x10 -> 0xDEAD55EF.
- Error cases (ADDR_WIDTH=10):
  - lw 0x00001000 -> err=1, rdata=0.
  - sw to 0x1000 leaves RAM unchanged.
  - load funct3=011 -> err=1.
  - With MEM_MISALIGN_CHECK_EN, lw 0x12 -> err=1; without it, lw 0x12 returns the word at 0x10 with err=0.
- req held high for 10 cycles with WAIT_CYCLES=0: one accept every 2 cycles, resp_valid on alternating cycles; with WAIT_CYCLES=3, resp_valid 4 cycles after each accept.
- sw 0x20 wdata=0x12345678 accepted, reset=0 asserted in WAIT: no resp_valid; after release, lw 0x20 returns prior contents (0x00000000 if never written).

Source files
------------

// File: rtl/mem_responder.sv
// mem_responder: unified word-organised RAM answering CPU fetch/load/store requests.
// Provides a req/ready handshake, WAIT_CYCLES wait states, RV32I byte/half/word sizing
// with load extension, and an error response for out-of-range or illegal accesses.
// Optional feature macro: MEM_MISALIGN_CHECK_EN (error on misaligned half/word accesses;
// when undefined the low address bits are forced to natural alignment).
module mem_responder #(
    parameter int unsigned ADDR_WIDTH  = 10,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [2:0]  funct3,
    input  logic [31:0] wdata,
    output logic        ready,
    output logic        resp_valid,
    output logic [31:0] rdata,
    output logic        err
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
    localparam int unsigned CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);
    localparam bit NO_WAIT = (WAIT_CYCLES == 0);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              we_q, we_d;
    logic [31:0]       addr_q, addr_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              ready_q, ready_d;
    logic              resp_valid_q, resp_valid_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              err_q, err_d;

    logic [31:0]       mem_q [DEPTH];

    // Access fields: live inputs when accepting in IDLE (zero-wait path), latched otherwise
    logic                  acc_we;
    logic [31:0]           acc_addr;
    logic [2:0]            acc_f3;
    logic [31:0]           acc_wdata;
    logic [ADDR_WIDTH-1:0] word_idx;
    logic [1:0]            lane_off;
    logic                  is_half, is_word;
    logic                  range_err, f3_err, align_err, acc_err;
    logic [31:0]           cur_word;
    logic [7:0]            byte_sel;
    logic [15:0]           half_sel;
    logic [31:0]           load_data;
    logic [3:0]            mem_be_c;
    logic [31:0]           mem_wdata_c;
    logic                  mem_we_c;

    // Select the request being serviced
    always_comb begin
        acc_we    = we_q;
        acc_addr  = addr_q;
        acc_f3    = funct3_q;
        acc_wdata = wdata_q;
        if (state_q == S_IDLE) begin
            acc_we    = we;
            acc_addr  = addr;
            acc_f3    = funct3;
            acc_wdata = wdata;
        end
    end

    // Decode address, size, errors, load extraction and store lane placement
    always_comb begin
        word_idx  = acc_addr[ADDR_WIDTH+1:2];
        is_half   = (acc_f3[1:0] == 2'b01);
        is_word   = (acc_f3[1:0] == 2'b10);
        range_err = |acc_addr[31:ADDR_WIDTH+2];
`ifdef MEM_MISALIGN_CHECK_EN
        align_err = (is_half && acc_addr[0]) || (is_word && (acc_addr[1:0] != 2'b00));
        lane_off  = acc_addr[1:0];
`else
        align_err = 1'b0;
        lane_off  = is_word ? 2'b00 : (is_half ? {acc_addr[1], 1'b0} : acc_addr[1:0]);
`endif
        if (acc_we) begin
            f3_err = !(acc_f3 == 3'b000 || acc_f3 == 3'b001 || acc_f3 == 3'b010);
        end else begin
            f3_err = (acc_f3 == 3'b011 || acc_f3 == 3'b110 || acc_f3 == 3'b111);
        end
        acc_err = range_err || f3_err || align_err;

        cur_word = mem_q[word_idx];
        case (lane_off)
            2'd0:    byte_sel = cur_word[7:0];
            2'd1:    byte_sel = cur_word[15:8];
            2'd2:    byte_sel = cur_word[23:16];
            default: byte_sel = cur_word[31:24];
        endcase
        half_sel = lane_off[1] ? cur_word[31:16] : cur_word[15:0];

        case (acc_f3)
            3'b000:  load_data = {{24{byte_sel[7]}}, byte_sel};
            3'b001:  load_data = {{16{half_sel[15]}}, half_sel};
            3'b010:  load_data = cur_word;
            3'b100:  load_data = {24'd0, byte_sel};
            3'b101:  load_data = {16'd0, half_sel};
            default: load_data = 32'd0;
        endcase

        case (acc_f3[1:0])
            2'b00: begin
                mem_be_c    = 4'b0001 << lane_off;
                mem_wdata_c = {4{acc_wdata[7:0]}};
            end
            2'b01: begin
                mem_be_c    = lane_off[1] ? 4'b1100 : 4'b0011;
                mem_wdata_c = {2{acc_wdata[15:0]}};
            end
            default: begin
                mem_be_c    = 4'b1111;
                mem_wdata_c = acc_wdata;
            end
        endcase
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        we_d         = we_q;
        addr_d       = addr_q;
        funct3_d     = funct3_q;
        wdata_d      = wdata_q;
        resp_valid_d = 1'b0;
        rdata_d      = 32'd0;
        err_d        = 1'b0;
        mem_we_c     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (req) begin
                    we_d     = we;
                    addr_d   = addr;
                    funct3_d = funct3;
                    wdata_d  = wdata;
                    cnt_d    = '0;
                    state_d  = NO_WAIT ? S_RESP : S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q == WAIT_LAST) begin
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // The RAM access happens on the edge that enters RESP
        if ((state_d == S_RESP) && (state_q != S_RESP)) begin
            resp_valid_d = 1'b1;
            err_d        = acc_err;
            rdata_d      = (acc_err || acc_we) ? 32'd0 : load_data;
            mem_we_c     = acc_we && !acc_err;
        end

        ready_d = (state_d == S_IDLE);
    end

    // State, request and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            we_q         <= 1'b0;
            addr_q       <= 32'd0;
            funct3_q     <= 3'd0;
            wdata_q      <= 32'd0;
            ready_q      <= 1'b1;
            resp_valid_q <= 1'b0;
            rdata_q      <= 32'd0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            funct3_q     <= funct3_d;
            wdata_q      <= wdata_d;
            ready_q      <= ready_d;
            resp_valid_q <= resp_valid_d;
            rdata_q      <= rdata_d;
            err_q        <= err_d;
        end
    end

    // RAM byte-lane write; contents survive reset, and reset drops a pending store
    always_ff @(posedge clk) begin
        if (reset && mem_we_c) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_be_c[b]) begin
                    mem_q[word_idx][8*b +: 8] <= mem_wdata_c[8*b +: 8];
                end
            end
        end
    end

    assign ready      = ready_q;
    assign resp_valid = resp_valid_q;
    assign rdata      = rdata_q;
    assign err        = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed testbench for mem_responder: main instance with WAIT_CYCLES=1 plus
// WAIT_CYCLES=0 and WAIT_CYCLES=3 instances sharing the same stimulus for throughput.
module tb_mem_responder;

    logic        clk;
    logic        reset;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [2:0]  funct3;
    logic [31:0] wdata;

    logic        ready,  resp_valid;
    logic [31:0] rdata;
    logic        err;
    logic        ready0, resp_valid0;
    logic [31:0] rdata0;
    logic        err0;
    logic        ready3, resp_valid3;
    logic [31:0] rdata3;
    logic        err3;

    int checks   = 0;
    int failures = 0;

    mem_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(1)) u_dut (
        .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .funct3(funct3),
        .wdata(wdata), .ready(ready), .resp_valid(resp_valid), .rdata(rdata), .err(err)
    );

    mem_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(0)) u_dut0 (
        .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .funct3(funct3),
        .wdata(wdata), .ready(ready0), .resp_valid(resp_valid0), .rdata(rdata0), .err(err0)
    );

    mem_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(3)) u_dut3 (
        .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .funct3(funct3),
        .wdata(wdata), .ready(ready3), .resp_valid(resp_valid3), .rdata(rdata3), .err(err3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One transaction on the main instance; inputs are scrambled after accept.
    // t_lat is cycles from accept to resp_valid, or -1 on timeout.
    task automatic do_txn(input logic t_we, input logic [31:0] t_addr, input logic [2:0] t_f3,
                          input logic [31:0] t_wdata, output logic [31:0] t_rdata,
                          output logic t_err, output int t_lat, output logic t_busy_ready,
                          output logic t_resp_after);
        int n;
        n = 0;
        while (!ready && n < 20) begin
            tick();
            n++;
        end
        we = t_we; addr = t_addr; funct3 = t_f3; wdata = t_wdata; req = 1'b1;
        tick();
        req = 1'b0; we = ~t_we; addr = 32'hFFFF_FFFC; funct3 = 3'b111; wdata = ~t_wdata;
        t_busy_ready = ready;
        t_lat = 1;
        while (!resp_valid && t_lat < 20) begin
            tick();
            t_lat++;
        end
        if (!resp_valid) t_lat = -1;
        t_rdata = rdata;
        t_err   = err;
        tick();
        t_resp_after = resp_valid;
    endtask

    task automatic test_reset();
        reset = 1'b0; req = 1'b0; we = 1'b0; addr = 32'd0; funct3 = 3'd0; wdata = 32'd0;
        repeat (3) tick();
        checks++; if (resp_valid !== 1'b0) begin failures++; $display("FAIL reset_in resp_valid: got %b expected 0", resp_valid); end
        reset = 1'b1;
        tick();
        checks++; if (ready !== 1'b1) begin failures++; $display("FAIL reset ready: got %b expected 1", ready); end
        checks++; if (resp_valid !== 1'b0) begin failures++; $display("FAIL reset resp_valid: got %b expected 0", resp_valid); end
        checks++; if (rdata !== 32'd0) begin failures++; $display("FAIL reset rdata: got %h expected 00000000", rdata); end
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset err: got %b expected 0", err); end
        checks++; if (ready0 !== 1'b1 || ready3 !== 1'b1) begin failures++; $display("FAIL reset ready0/3: got %b/%b expected 1/1", ready0, ready3); end
    endtask

    task automatic test_store_load();
        logic [31:0] rd; logic er, br, ra; int lat;
        do_txn(1'b1, 32'h10, 3'b010, 32'hDEADBEEF, rd, er, lat, br, ra);
        checks++; if (lat !== 2) begin failures++; $display("FAIL sw latency: got %0d expected 2", lat); end
        checks++; if (er !== 1'b0 || rd !== 32'd0) begin failures++; $display("FAIL sw resp: got err=%b rdata=%h expected err=0 rdata=00000000", er, rd); end
        checks++; if (br !== 1'b0) begin failures++; $display("FAIL busy ready: got %b expected 0", br); end
        checks++; if (ra !== 1'b0) begin failures++; $display("FAIL resp one-cycle: got %b expected 0", ra); end
        do_txn(1'b0, 32'h10, 3'b010, 32'd0, rd, er, lat, br, ra);
        checks++; if (rd !== 32'hDEADBEEF || er !== 1'b0) begin failures++; $display("FAIL lw 0x10: got %h err=%b expected deadbeef err=0", rd, er); end
        checks++; if (lat !== 2) begin failures++; $display("FAIL lw latency: got %0d expected 2", lat); end
    endtask

    task automatic test_extension();
        logic [31:0] rd; logic er, br, ra; int lat;
        do_txn(1'b0, 32'h13, 3'b000, 32'd0, rd, er, lat, br, ra);
        checks++; if (rd !== 32'hFFFFFFDE) begin failures++; $display("FAIL lb 0x13: got %h expected ffffffde", rd); end
        do_txn(1'b0, 32'h13, 3'b100, 32'd0, rd, er, lat, br, ra);
        checks++; if (rd !== 32'h000000DE) begin failures++; $display("FAIL lbu 0x13: got %h expected 000000de", rd); end
        do_txn(1'b0, 32'h12, 3'b001, 32'd0, rd, er, lat, br, ra);
        checks++; if (rd !== 32'hFFFFDEAD) begin failures++; $display("FAIL lh 0x12: got %h expected ffffdead", rd); end
        do_txn(1'b0, 32'h10, 3'b101, 32'd0, rd, er, lat, br, ra);
        checks++; if (rd !== 32'h0000BEEF) begin failures++; $display("FAIL lhu 0x10: got %h expected 0000beef", rd); end
        do_txn(1'b1, 32'h11, 3'b000, 32'h00000055, rd, er, lat, br, ra);
        checks++; if (er !== 1'b0 || rd !== 32'd0) begin failures++; $display("FAIL sb resp: got err=%b rdata=%h expected 0/00000000", er, rd); end
        do_txn(1'b0, 32'h10, 3'b010, 32'd0, rd, er, lat, br, ra);
        checks++; if (rd !== 32'hDEAD55EF) begin failures++; $display("FAIL lw after sb: got %h expected dead55ef", rd); end
        do_txn(1'b1, 32'h12, 3'b001, 32'hFFFF1234, rd, er, lat, br, ra);
        do_txn(1'b0, 32'h10, 3'b010, 32'd0, rd, er, lat, br, ra);
        checks++; if (rd !== 32'h123455EF) begin failures++; $display("FAIL lw after sh: got %h expected 123455ef", rd); end
        do_txn(1'b0, 32'h10, 3'b001, 32'd0, rd, er, lat, br, ra);
        checks++; if (rd !== 32'h000055EF) begin failures++; $display("FAIL lh 0x10: got %h expected 000055ef", rd); end
        do_txn(1'b0, 32'h10, 3'b000, 32'd0, rd, er, lat, br, ra);
        checks++; if (rd !== 32'hFFFFFFEF) begin failures++; $display("FAIL lb 0x10: got %h expected ffffffef", rd); end
    endtask

    task automatic test_errors();
        logic [31:0] rd; logic er, br, ra; int lat;
        do_txn(1'b0, 32'h00001000, 3'b010, 32'd0, rd, er, lat, br, ra);
        checks++; if (er !== 1'b1 || rd !== 32'd0) begin failures++; $display("FAIL lw range: got err=%b rdata=%h expected 1/00000000", er, rd); end
        do_txn(1'b1, 32'h0, 3'b010, 32'h11111111, rd, er, lat, br, ra);
        do_txn(1'b1, 32'h00001000, 3'b010, 32'hCAFEF00D, rd, er, lat, br, ra);
        checks++; if (er !== 1'b1) begin failures++; $display("FAIL sw range err: got %b expected 1", er); end
        do_txn(1'b0, 32'h0, 3'b010, 32'd0, rd, er, lat, br, ra);
        checks++; if (rd !== 32'h11111111) begin failures++; $display("FAIL ram after sw range: got %h expected 11111111", rd); end
        do_txn(1'b0, 32'h10, 3'b011, 32'd0, rd, er, lat, br, ra);
        checks++; if (er !== 1'b1 || rd !== 32'd0) begin failures++; $display("FAIL load f3=011: got err=%b rdata=%h expected 1/00000000", er, rd); end
        do_txn(1'b0, 32'h10, 3'b110, 32'd0, rd, er, lat, br, ra);
        checks++; if (er !== 1'b1) begin failures++; $display("FAIL load f3=110: got err=%b expected 1", er); end
        do_txn(1'b1, 32'h10, 3'b100, 32'd0, rd, er, lat, br, ra);
        checks++; if (er !== 1'b1) begin failures++; $display("FAIL store f3=100: got err=%b expected 1", er); end
        do_txn(1'b0, 32'h10, 3'b010, 32'd0, rd, er, lat, br, ra);
        checks++; if (rd !== 32'h123455EF || er !== 1'b0) begin failures++; $display("FAIL ram after bad store: got %h err=%b expected 123455ef err=0", rd, er); end
    endtask

    task automatic test_misalign();
        logic [31:0] rd; logic er, br, ra; int lat;
        do_txn(1'b0, 32'h12, 3'b010, 32'd0, rd, er, lat, br, ra);
`ifdef MEM_MISALIGN_CHECK_EN
        checks++; if (er !== 1'b1 || rd !== 32'd0) begin failures++; $display("FAIL lw 0x12 misalign: got err=%b rdata=%h expected 1/00000000", er, rd); end
`else
        checks++; if (er !== 1'b0 || rd !== 32'h123455EF) begin failures++; $display("FAIL lw 0x12 aligned: got err=%b rdata=%h expected 0/123455ef", er, rd); end
`endif
        do_txn(1'b0, 32'h13, 3'b001, 32'd0, rd, er, lat, br, ra);
`ifdef MEM_MISALIGN_CHECK_EN
        checks++; if (er !== 1'b1 || rd !== 32'd0) begin failures++; $display("FAIL lh 0x13 misalign: got err=%b rdata=%h expected 1/00000000", er, rd); end
`else
        checks++; if (er !== 1'b0 || rd !== 32'h00001234) begin failures++; $display("FAIL lh 0x13 aligned: got err=%b rdata=%h expected 0/00001234", er, rd); end
`endif
    endtask

    task automatic test_back_to_back();
        req = 1'b0;
        repeat (6) tick();
        we = 1'b0; addr = 32'h10; funct3 = 3'b010; wdata = 32'd0; req = 1'b1;
        for (int i = 0; i < 10; i++) begin
            checks++; if (ready0 !== (i % 2 == 0)) begin failures++; $display("FAIL w0 ready cyc%0d: got %b expected %b", i, ready0, (i % 2 == 0)); end
            checks++; if (resp_valid0 !== (i % 2 == 1)) begin failures++; $display("FAIL w0 resp_valid cyc%0d: got %b expected %b", i, resp_valid0, (i % 2 == 1)); end
            if (i == 1) begin
                checks++; if (rdata0 !== 32'h123455EF) begin failures++; $display("FAIL w0 rdata: got %h expected 123455ef", rdata0); end
            end
            tick();
        end
        req = 1'b0;
        repeat (6) tick();
        req = 1'b1;
        for (int i = 0; i < 12; i++) begin
            checks++; if (ready3 !== (i % 5 == 0)) begin failures++; $display("FAIL w3 ready cyc%0d: got %b expected %b", i, ready3, (i % 5 == 0)); end
            checks++; if (resp_valid3 !== (i % 5 == 4)) begin failures++; $display("FAIL w3 resp_valid cyc%0d: got %b expected %b", i, resp_valid3, (i % 5 == 4)); end
            tick();
        end
        req = 1'b0;
        repeat (6) tick();
    endtask

    task automatic test_reset_abort();
        logic [31:0] rd; logic er, br, ra; int lat;
        do_txn(1'b1, 32'h20, 3'b010, 32'hA5A5A5A5, rd, er, lat, br, ra);
        we = 1'b1; addr = 32'h20; funct3 = 3'b010; wdata = 32'h12345678; req = 1'b1;
        tick();
        req = 1'b0;
        checks++; if (ready !== 1'b0) begin failures++; $display("FAIL abort in WAIT ready: got %b expected 0", ready); end
        reset = 1'b0;
        tick();
        checks++; if (resp_valid !== 1'b0) begin failures++; $display("FAIL abort resp_valid: got %b expected 0", resp_valid); end
        tick();
        reset = 1'b1;
        tick();
        checks++; if (resp_valid !== 1'b0 || ready !== 1'b1) begin failures++; $display("FAIL after abort: got resp_valid=%b ready=%b expected 0/1", resp_valid, ready); end
        do_txn(1'b0, 32'h20, 3'b010, 32'd0, rd, er, lat, br, ra);
        checks++; if (rd !== 32'hA5A5A5A5 || er !== 1'b0) begin failures++; $display("FAIL lw 0x20 after abort: got %h err=%b expected a5a5a5a5 err=0", rd, er); end
    endtask

    initial begin
        test_reset();
        test_store_load();
        test_extension();
        test_errors();
        test_misalign();
        test_back_to_back();
        test_reset_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
